// File: rtl/textmode_timing.sv
// Text-mode raster timing: pixel enable, h/v counters, cell coordinates,
// delayed blank/syncs and blink. Optional cursor overlay: TEXTMODE_CURSOR_EN.
module textmode_timing #(
  parameter int H_VISIBLE     = 640,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33,
  parameter int FETCH_LATENCY = 2,
  parameter int BLINK_FRAMES  = 16
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pixclk,
  output logic [6:0] char_col,
  output logic [4:0] char_row,
  output logic [3:0] glyph_row,
  output logic [2:0] glyph_col,
  output logic       fetch_valid,
  output logic       blank,
  output logic       hsync,
  output logic       vsync,
  output logic       blink,
  output logic       frame_start
`ifdef TEXTMODE_CURSOR_EN
  ,
  input  logic [6:0] cursor_col,
  input  logic [4:0] cursor_row,
  output logic       cursor
`endif
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int HW = (H_TOTAL > 1024) ? $clog2(H_TOTAL) : 10;
  localparam int VW = (V_TOTAL > 512) ? $clog2(V_TOTAL) : 9;
  localparam int L  = FETCH_LATENCY;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [7:0]    frame_cnt;
  logic          tick;
  logic          h_last;
  logic          v_last;
  logic          fv_c;
  logic          hs_c;
  logic          vs_c;
  logic          hs_u;
  logic          vs_u;
  logic [L-1:0]  blank_d;
  logic [L-1:0]  hs_d;
  logic [L-1:0]  vs_d;

  assign tick   = pixclk;
  assign h_last = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last = (v_cnt == VW'(V_TOTAL - 1));

  always_comb begin
    fv_c = (h_cnt < HW'(H_VISIBLE)) && (v_cnt < VW'(V_VISIBLE));
    hs_c = !((h_cnt >= HW'(HS_START)) && (h_cnt < HW'(HS_END)));
    vs_c = !((v_cnt >= VW'(VS_START)) && (v_cnt < VW'(VS_END)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pixclk      <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_cnt   <= '0;
      blink       <= 1'b0;
      frame_start <= 1'b0;
      char_col    <= '0;
      char_row    <= '0;
      glyph_row   <= '0;
      glyph_col   <= '0;
      fetch_valid <= 1'b0;
      hs_u        <= 1'b1;
      vs_u        <= 1'b1;
      blank_d     <= '0;
      hs_d        <= '1;
      vs_d        <= '1;
    end else begin
      pixclk      <= ~pixclk;
      frame_start <= tick & h_last & v_last;
      if (tick) begin
        h_cnt <= h_last ? '0 : h_cnt + 1'b1;
        if (h_last) begin
          v_cnt <= v_last ? '0 : v_cnt + 1'b1;
          // blink flips on the same tick the frame wraps
          if (v_last) begin
            if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
              frame_cnt <= '0;
              blink     <= ~blink;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        glyph_col   <= h_cnt[2:0];
        char_col    <= h_cnt[9:3];
        glyph_row   <= v_cnt[3:0];
        char_row    <= v_cnt[8:4];
        fetch_valid <= fv_c;
        hs_u        <= hs_c;
        vs_u        <= vs_c;
        blank_d[0]  <= fetch_valid;
        hs_d[0]     <= hs_u;
        vs_d[0]     <= vs_u;
        for (int i = 1; i < L; i++) begin
          blank_d[i] <= blank_d[i-1];
          hs_d[i]    <= hs_d[i-1];
          vs_d[i]    <= vs_d[i-1];
        end
      end
    end
  end

  assign blank = blank_d[L-1];
  assign hsync = hs_d[L-1];
  assign vsync = vs_d[L-1];

`ifdef TEXTMODE_CURSOR_EN
  logic         cur_c;
  logic         cur_u;
  logic [L-1:0] cur_d;

  always_comb begin
    cur_c = fv_c && (h_cnt[9:3] == cursor_col) && (v_cnt[8:4] == cursor_row)
         && (v_cnt[3:0] >= 4'd14) && blink;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_u <= 1'b0;
      cur_d <= '0;
    end else if (tick) begin
      cur_u    <= cur_c;
      cur_d[0] <= cur_u;
      for (int i = 1; i < L; i++) begin
        cur_d[i] <= cur_d[i-1];
      end
    end
  end

  assign cursor = cur_d[L-1];
`endif

endmodule

// File: tb/tb_textmode_timing.sv
// Scoreboard bench for textmode_timing on a shrunken raster; the model
// derives every output from the pixel-tick count since reset release.
module tb_textmode_timing;

  localparam int HV = 32, HF = 4, HS = 8, HB = 4;
  localparam int VV = 32, VF = 2, VS = 2, VB = 2;
  localparam int LAT = 3, BF = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pixclk;
  logic [6:0] char_col;
  logic [4:0] char_row;
  logic [3:0] glyph_row;
  logic [2:0] glyph_col;
  logic       fetch_valid, blank, hsync, vsync, blink, frame_start;
`ifdef TEXTMODE_CURSOR_EN
  logic [6:0] cursor_col = '0;
  logic [4:0] cursor_row = '0;
  logic       cursor;
`endif

  textmode_timing #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .FETCH_LATENCY(LAT), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .reset(reset), .pixclk(pixclk),
    .char_col(char_col), .char_row(char_row),
    .glyph_row(glyph_row), .glyph_col(glyph_col),
    .fetch_valid(fetch_valid), .blank(blank),
    .hsync(hsync), .vsync(vsync), .blink(blink),
    .frame_start(frame_start)
`ifdef TEXTMODE_CURSOR_EN
    , .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor(cursor)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int pix, fs, fv, blank, hs, vs, blink, cur;
    int coords, cc, cr, gr, gc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  int n = 0;
  int mpix = 0;
  int ccol = 1;
  int crow = 1;

  function automatic int hpos(int t); return t % HT; endfunction
  function automatic int vpos(int t); return (t / HT) % VT; endfunction
  function automatic int vis(int t);
    return (hpos(t) < HV && vpos(t) < VV) ? 1 : 0;
  endfunction
  function automatic int blink_after(int t);
    return ((t / FRAME) / BF) % 2;
  endfunction

  function automatic exp_t model(int ticks, int pix, int fs);
    exp_t e;
    int p, q;
    e.pix = pix;
    e.fs = fs;
    e.blink = blink_after(ticks);
    e.coords = 1;
    e.cc = 0; e.cr = 0; e.gr = 0; e.gc = 0; e.fv = 0;
    if (ticks > 0) begin
      p = ticks - 1;
      e.fv = vis(p);
      e.coords = e.fv;
      e.gc = hpos(p) % 8;
      e.cc = hpos(p) / 8;
      e.gr = vpos(p) % 16;
      e.cr = vpos(p) / 16;
    end
    q = ticks - 1 - LAT;
    e.blank = 0; e.hs = 1; e.vs = 1; e.cur = 0;
    if (q >= 0) begin
      e.blank = vis(q);
      e.hs = (hpos(q) >= HV + HF && hpos(q) < HV + HF + HS) ? 0 : 1;
      e.vs = (vpos(q) >= VV + VF && vpos(q) < VV + VF + VS) ? 0 : 1;
      e.cur = (vis(q) == 1 && hpos(q) / 8 == ccol && vpos(q) / 16 == crow
               && vpos(q) % 16 >= 14 && blink_after(q) == 1) ? 1 : 0;
    end
    return e;
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  task automatic drive_cycle(bit r);
    int fs;
    @(negedge clk);
    reset = r;
    fs = 0;
    if (r) begin
      mpix = 0;
      n = 0;
    end else begin
      if (mpix == 1) begin
        n++;
        fs = (n % FRAME == 0) ? 1 : 0;
      end
      mpix = 1 - mpix;
    end
    sb.push_back(model(n, mpix, fs));
  endtask

  task automatic do_reset(int cycles);
    ccol = $urandom_range(0, 3);
    crow = $urandom_range(0, 1);
`ifdef TEXTMODE_CURSOR_EN
    cursor_col = 7'(ccol);
    cursor_row = 5'(crow);
`endif
    repeat (cycles) drive_cycle(1'b1);
  endtask

  task automatic run(int cycles);
    repeat (cycles) drive_cycle(1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pixclk", int'(pixclk), e.pix);
        chk("frame_start", int'(frame_start), e.fs);
        chk("fetch_valid", int'(fetch_valid), e.fv);
        chk("blank", int'(blank), e.blank);
        chk("hsync", int'(hsync), e.hs);
        chk("vsync", int'(vsync), e.vs);
        chk("blink", int'(blink), e.blink);
`ifdef TEXTMODE_CURSOR_EN
        chk("cursor", int'(cursor), e.cur);
`endif
        if (e.coords != 0) begin
          chk("char_col", int'(char_col), e.cc);
          chk("char_row", int'(char_row), e.cr);
          chk("glyph_row", int'(glyph_row), e.gr);
          chk("glyph_col", int'(glyph_col), e.gc);
        end
      end
    end
  end

  initial begin : driver
    do_reset(3);
    run(5 * FRAME * 2 + int'($urandom_range(0, 500)));
    for (int i = 0; i < 5; i++) begin
      do_reset(int'($urandom_range(1, 3)));
      run(int'($urandom_range(50, 3000)));
    end
    do_reset(1);
    run(3 * FRAME * 2 + 20);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
